// File: rtl/i2s_rx_arbiter.sv
// Merges up to four I2S RX sample streams into one tagged, registered 32-bit stream.
// Optional per-source overflow counters are enabled with `define I2S_RX_ARB_ERR_CNT_EN.

// state    | meaning
// ST_EMPTY | output register holds no sample
// ST_FULL  | output register holds a sample waiting for out_ready_i
module i2s_rx_arbiter #(
  parameter int NB_CH = 2,
  parameter int ID_W  = 2
) (
  input  logic                  sck_i,
  input  logic                  rst_i,
  input  logic                  cfg_en_i,
  input  logic [NB_CH-1:0]      cfg_ch_mask_i,
  input  logic                  cfg_rr_i,
  input  logic                  cfg_clr_i,
  input  logic [NB_CH*32-1:0]   req_data_i,
  input  logic [NB_CH-1:0]      req_valid_i,
  output logic [NB_CH-1:0]      req_ready_o,
  input  logic [NB_CH-1:0]      req_err_i,
  output logic [31:0]           out_data_o,
  output logic [ID_W-1:0]       out_id_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NB_CH-1:0]      err_o,
  output logic [NB_CH*8-1:0]    err_cnt_o,
  output logic                  busy_o
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win_lo, win_hi, win;
  logic             found_lo, found_hi;
  logic             can_load, grant;
  logic [NB_CH-1:0] elig, gnt, err_set;
  logic [31:0]      sel_data;

  // win_lo is the lowest eligible index; win_hi the lowest eligible above ptr.
  // Round robin takes win_hi and wraps to win_lo when nothing lies above ptr.
  always_comb begin
    elig     = {NB_CH{cfg_en_i}} & cfg_ch_mask_i & req_valid_i;
    can_load = (state == ST_EMPTY) | out_ready_i;
    win_lo   = '0;
    win_hi   = '0;
    found_lo = 1'b0;
    found_hi = 1'b0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win_lo   = ID_W'(i);
        found_lo = 1'b1;
        if (ID_W'(i) > ptr) begin
          win_hi   = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    win      = (cfg_rr_i && found_hi) ? win_hi : win_lo;
    grant    = can_load & found_lo;
    sel_data = '0;
    gnt      = '0;
    for (int i = 0; i < NB_CH; i++) begin
      if (win == ID_W'(i)) begin
        sel_data = req_data_i[32*i +: 32];
        gnt[i]   = grant;
      end
    end
    req_ready_o = (req_valid_i & ~elig) | gnt;
  end

  assign out_valid_o = (state == ST_FULL);
  assign busy_o      = (state == ST_FULL) | (|elig);
  assign err_set     = req_err_i & cfg_ch_mask_i;

  always_ff @(posedge sck_i) begin
    if (rst_i) begin
      state      <= ST_EMPTY;
      out_data_o <= '0;
      out_id_o   <= '0;
      ptr        <= ID_W'(NB_CH - 1);
    end else if (grant) begin
      state      <= ST_FULL;
      out_data_o <= sel_data;
      out_id_o   <= win;
      if (cfg_rr_i) ptr <= win;
    end else if (state == ST_FULL && out_ready_i) begin
      state <= ST_EMPTY;
    end
  end

  // A set on the same edge as a clear wins.
  always_ff @(posedge sck_i) begin
    if (rst_i) err_o <= '0;
    else       err_o <= (cfg_clr_i ? '0 : err_o) | err_set;
  end

`ifdef I2S_RX_ARB_ERR_CNT_EN
  logic [7:0] cnt [NB_CH];

  always_ff @(posedge sck_i) begin
    for (int i = 0; i < NB_CH; i++) begin
      if (rst_i)
        cnt[i] <= '0;
      else if (err_set[i])
        cnt[i] <= cfg_clr_i ? 8'd1 : ((cnt[i] == 8'hFF) ? cnt[i] : cnt[i] + 8'd1);
      else if (cfg_clr_i)
        cnt[i] <= '0;
    end
  end

  always_comb begin
    err_cnt_o = '0;
    for (int i = 0; i < NB_CH; i++) err_cnt_o[8*i +: 8] = cnt[i];
  end
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_i2s_rx_arbiter.sv
// Self-checking bench for i2s_rx_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of the arbitration rules.
module tb_i2s_rx_arbiter;
  localparam int NB_CH = 2;
  localparam int ID_W  = 2;

  logic                 sck = 1'b0;
  logic                 rst;
  logic                 cfg_en, cfg_rr, cfg_clr;
  logic [NB_CH-1:0]     cfg_mask;
  logic [NB_CH*32-1:0]  req_data;
  logic [31:0]          src_data [NB_CH];
  logic [NB_CH-1:0]     req_valid, req_ready, req_err;
  logic [31:0]          out_data;
  logic [ID_W-1:0]      out_id;
  logic                 out_valid, out_ready, busy;
  logic [NB_CH-1:0]     err;
  logic [NB_CH*8-1:0]   err_cnt;

  always #5 sck = ~sck;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NB_CH; i++) req_data[32*i +: 32] = src_data[i];
  end

  i2s_rx_arbiter #(.NB_CH(NB_CH), .ID_W(ID_W)) dut (
    .sck_i(sck), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_ch_mask_i(cfg_mask),
    .cfg_rr_i(cfg_rr), .cfg_clr_i(cfg_clr), .req_data_i(req_data),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_err_i(req_err),
    .out_data_o(out_data), .out_id_o(out_id), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .err_o(err), .err_cnt_o(err_cnt), .busy_o(busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_init = 0;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_id, m_ptr;
  bit          m_err [NB_CH];
  int          m_cnt [NB_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb(output logic [NB_CH-1:0] rdy, output logic bsy,
                            output int w, output bit g);
    bit e [NB_CH];
    for (int i = 0; i < NB_CH; i++) e[i] = cfg_en && cfg_mask[i] && req_valid[i];
    w = -1;
    if (cfg_rr) begin
      for (int k = 1; k <= NB_CH; k++)
        if (w < 0 && e[(m_ptr + k) % NB_CH]) w = (m_ptr + k) % NB_CH;
    end else begin
      for (int j = 0; j < NB_CH; j++)
        if (w < 0 && e[j]) w = j;
    end
    g = (w >= 0) && (!m_valid || out_ready);
    for (int i = 0; i < NB_CH; i++)
      rdy[i] = (req_valid[i] && !e[i]) || (g && w == i);
    bsy = m_valid || (w >= 0);
  endtask

  task automatic model_edge();
    logic [NB_CH-1:0] rdy;
    logic bsy;
    int w;
    bit g, s;
    model_comb(rdy, bsy, w, g);
    if (rst) begin
      m_valid = 0; m_data = '0; m_id = 0; m_ptr = NB_CH - 1; m_init = 1;
      for (int i = 0; i < NB_CH; i++) begin m_err[i] = 0; m_cnt[i] = 0; end
    end else begin
      if (g) begin
        m_valid = 1; m_data = src_data[w]; m_id = w;
        if (cfg_rr) m_ptr = w;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      for (int i = 0; i < NB_CH; i++) begin
        s = req_err[i] && cfg_mask[i];
        if (s) begin
          m_err[i] = 1;
          m_cnt[i] = cfg_clr ? 1 : ((m_cnt[i] < 255) ? m_cnt[i] + 1 : 255);
        end else if (cfg_clr) begin
          m_err[i] = 0;
          m_cnt[i] = 0;
        end
      end
    end
  endtask

  // Inputs are applied just after a falling edge; one call spans one rising edge.
  task automatic cycle();
    logic [NB_CH-1:0]   rdy;
    logic               bsy;
    int                 w;
    bit                 g;
    logic [NB_CH-1:0]   e_err;
    logic [NB_CH*8-1:0] e_cnt;
    #1;
    if (m_init) begin
      model_comb(rdy, bsy, w, g);
      chk("req_ready", 32'(req_ready), 32'(rdy));
      chk("busy", 32'(busy), 32'(bsy));
    end
    @(posedge sck);
    model_edge();
    @(negedge sck);
    e_cnt = '0;
    for (int i = 0; i < NB_CH; i++) begin
      e_err[i] = m_err[i];
`ifdef I2S_RX_ARB_ERR_CNT_EN
      e_cnt[8*i +: 8] = 8'(m_cnt[i]);
`endif
    end
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", out_data, m_data);
    chk("out_id", 32'(out_id), 32'(m_id));
    chk("err", 32'(err), 32'(e_err));
    chk("err_cnt", 32'(err_cnt), 32'(e_cnt));
  endtask

  function automatic logic [7:0] exp_cnt(input int v);
`ifdef I2S_RX_ARB_ERR_CNT_EN
    return 8'(v);
`else
    return 8'(v * 0);
`endif
  endfunction

  logic [31:0] held;

  initial begin
    rst = 1; cfg_en = 0; cfg_rr = 1; cfg_clr = 0; cfg_mask = '0;
    req_valid = '0; req_err = '0; out_ready = 1;
    for (int i = 0; i < NB_CH; i++) src_data[i] = '0;
    @(negedge sck);
    cycle(); cycle();
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    // Round robin, both sources streaming
    rst = 0; cfg_en = 1; cfg_mask = 2'b11; cfg_rr = 1; req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      src_data[0] = 32'hA000_0000 + 32'(k);
      src_data[1] = 32'hB000_0000 + 32'(k);
      cycle();
      chk("rr_seq_id", 32'(out_id), 32'(k % 2));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Fixed priority
    cfg_rr = 0;
    for (int k = 0; k < 4; k++) begin
      src_data[0] = 32'hA100_0000 + 32'(k);
      cycle();
      chk("fp_ready", 32'(req_ready), 32'b01);
      chk("fp_id", 32'(out_id), 32'd0);
    end
    req_valid = 2'b10;
    cycle();
    chk("fp_src1_id", 32'(out_id), 32'd1);

    // Backpressure: hold then back-to-back reload
    req_valid = 2'b11; cycle();
    out_ready = 0; held = out_data;
    for (int k = 0; k < 5; k++) begin
      src_data[0] = 32'hA200_0000 + 32'(k);
      cycle();
      chk("hold_data", out_data, held);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1; src_data[0] = 32'hA2FF_0000;
    cycle();
    chk("reload_valid", 32'(out_valid), 32'd1);
    chk("reload_data", out_data, 32'hA2FF_0000);

    // Masked source is drained
    cfg_rr = 1; cfg_mask = 2'b01; req_valid = 2'b10; src_data[1] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drain_ready", 32'(req_ready[1]), 32'd1);
      chk("drain_no_data", 32'(out_data == 32'hDEAD_BEEF), 32'd0);
    end

    // Error flags and counters
    cfg_mask = 2'b11; req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      req_err = 2'b10; cycle();
      req_err = 2'b00; cycle();
    end
    chk("err3_flag", 32'(err[1]), 32'd1);
    chk("err3_cnt", 32'(err_cnt[15:8]), 32'(exp_cnt(3)));
    cfg_clr = 1; req_err = 2'b10; cycle();
    cfg_clr = 0; req_err = 2'b00;
    chk("clr_set_flag", 32'(err[1]), 32'd1);
    chk("clr_set_cnt", 32'(err_cnt[15:8]), 32'(exp_cnt(1)));
    req_err = 2'b10;
    for (int k = 0; k < 300; k++) cycle();
    req_err = 2'b00; cycle();
    chk("sat_cnt", 32'(err_cnt[15:8]), 32'(exp_cnt(255)));
    cfg_clr = 1; cycle(); cfg_clr = 0;
    chk("clr_flag", 32'(err), 32'd0);

    // Reset while FULL
    req_valid = 2'b11; out_ready = 0; cycle(); cycle();
    rst = 1; cycle();
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    rst = 0; out_ready = 1; cycle();
    chk("rst_first_id", 32'(out_id), 32'd0);
    chk("rst_first_valid", 32'(out_valid), 32'd1);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NB_CH; i++) src_data[i] = $urandom;
      req_valid = NB_CH'($urandom);
      out_ready = ($urandom_range(3) != 0);
      cfg_mask  = ($urandom_range(7) == 0) ? NB_CH'($urandom) : '1;
      cfg_en    = ($urandom_range(15) != 0);
      if ($urandom_range(31) == 0) cfg_rr = ~cfg_rr;
      req_err   = ($urandom_range(7) == 0) ? NB_CH'($urandom) : '0;
      cfg_clr   = ($urandom_range(15) == 0);
      rst       = ($urandom_range(63) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
